axi_alu_unit: RTL and testbench
===============================

// Module: axi_alu_unit
// PURPOSE
//  Downstream consumer of the byte FIFO: pops a 3-beat frame {opcode, A, B}, executes one ALU op,
//  and presents a DATA_W+1-bit result (carry/borrow in MSB) on a valid/ready output channel.
//  Sits between the operand FIFO read port and the result sink (register file / response path).
// PARAMETERS
//  DATA_W  8   operand width; result width is DATA_W+1
//  CNT_W   16  width of completed-operation counter
// PORTS
//  clk       in   1         clock; all state on rising edge
//  reset     in   1         asynchronous, active-low reset
//  s_data    in   DATA_W    input beat (opcode, then A, then B)
//  s_valid   in   1         input beat valid
//  s_ready   out  1         block can accept a beat
//  m_data    out  DATA_W+1  result; MSB = carry/borrow/shift-out
//  m_valid   out  1         result valid
//  m_ready   in   1         sink accepts result
//  busy      out  1         high in any state except IDLE
//  op_count  out  CNT_W     completed ops (output handshakes), saturating
//  status    out  2         [0]=zero result, [1]=illegal opcode; present only with ALU_STATUS_EN
// BEHAVIOUR
//  - Beat transfer when s_valid && s_ready; result transfer when m_valid && m_ready.
//  - FSM: IDLE -(beat: latch opcode)-> GET_A -(beat: latch A)-> GET_B -(beat: compute)-> OUT
//    -(m_ready)-> IDLE. No beat = stay. s_ready=1 in IDLE/GET_A/GET_B, 0 in OUT.
//  - Latency: m_valid rises the cycle after the B beat; m_data registered at that edge.
//  - In OUT m_valid held high, m_data stable until handshake; s_ready rises cycle after handshake
//    (no bypass). Peak throughput: 1 op per 4 cycles.
//  - Opcode = low 3 bits of beat 0; upper bits must be 0, else illegal.
//    0 ADD  {c,A+B}          1 SUB  {borrow,A-B} (borrow=1 if A<B)
//    2 AND  {0,A&B}          3 OR   {0,A|B}       4 XOR  {0,A^B}
//    5 SHL  {A,1'b0}<<sh >> 1 i.e. {shifted-out bit, A<<sh}, sh=B[$clog2(DATA_W)-1:0]
//    6 SHR  {0,A>>sh}        7 PASS {0,A}
//  - Illegal opcode: frame still consumes A and B; m_data = 0.
//  - All arithmetic modulo 2^(DATA_W+1); A, B zero-extended.
//  - op_count +1 per result handshake; holds at 2^CNT_W-1.
//  - Reset (any time, incl. mid-frame): state IDLE, partial frame discarded, m_valid=0, m_data=0,
//    busy=0, op_count=0, status=0; s_ready=1 first cycle after reset deasserts.
//  - m_ready high while m_valid low is ignored; s_valid in OUT is ignored (not accepted).
// CONFIGURATION
//  ALU_STATUS_EN defined: status port exists, registered alongside m_data, held with it in OUT;
//    status[0]=(m_data==0), status[1]=illegal opcode; reset 0.
//  ALU_STATUS_EN undefined: no status port, no flag logic; all else identical.
// TESTING
//  - Frame {0x00,0xFF,0x01}, m_ready=1 -> m_data=0x100, m_valid 1 cycle after B beat, op_count=1.
//  - Frame {0x01,0x03,0x05} -> m_data=0x1FE (borrow=1); {0x05,0x81,0x01} -> m_data=0x102.
//  - m_ready=0 for 5 cycles after result: m_valid/m_data stable, s_ready=0, s_valid beats not taken.
//  - Opcode 0x09 frame -> m_data=0x000; with ALU_STATUS_EN status=2'b11.
//  - Reset asserted after A beat -> next frame {0x07,0x2A,0x00} gives m_data=0x02A.
//  - CNT_W=2, 5 back-to-back ops -> op_count sequence 1,2,3,3,3.

Source files
------------

// File: rtl/axi_alu_unit.sv
// Frame-driven ALU: pops {opcode, A, B} beats and presents a carry-extended result on a valid/ready channel.
// Optional zero/illegal status flags are built only when `define ALU_STATUS_EN is set.
module axi_alu_unit #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W:0]   m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              busy,
    output logic [CNT_W-1:0]  op_count
`ifdef ALU_STATUS_EN
    ,
    output logic [1:0]        status
`endif
);
    localparam int SH_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {IDLE, GET_A, GET_B, OUT} state_t;

    state_t            state;
    logic [2:0]        opcode;
    logic              illegal;
    logic [DATA_W-1:0] a_reg;
    logic [DATA_W:0]   result;
    logic              s_fire;
    logic              m_fire;

    // Operands are zero-extended by one bit so the MSB carries carry/borrow/shift-out.
    function automatic logic [DATA_W:0] alu_result(
        input logic [2:0]        op,
        input logic              bad,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic [DATA_W:0] ax;
        logic [DATA_W:0] bx;
        logic [SH_W-1:0] sh;
        ax = {1'b0, a};
        bx = {1'b0, b};
        sh = b[SH_W-1:0];
        alu_result = '0;
        if (!bad) begin
            case (op)
                3'd0:    alu_result = ax + bx;
                3'd1:    alu_result = ax - bx;
                3'd2:    alu_result = ax & bx;
                3'd3:    alu_result = ax | bx;
                3'd4:    alu_result = ax ^ bx;
                3'd5:    alu_result = ax << sh;
                3'd6:    alu_result = ax >> sh;
                default: alu_result = ax;
            endcase
        end
    endfunction

    assign s_fire = s_valid && s_ready;
    assign m_fire = m_valid && m_ready;
    assign result = alu_result(opcode, illegal, a_reg, s_data);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            s_ready  <= 1'b1;
            m_valid  <= 1'b0;
            busy     <= 1'b0;
            m_data   <= '0;
            op_count <= '0;
            opcode   <= '0;
            illegal  <= 1'b0;
            a_reg    <= '0;
`ifdef ALU_STATUS_EN
            status   <= 2'b00;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (s_fire) begin
                        opcode  <= s_data[2:0];
                        illegal <= |s_data[DATA_W-1:3];
                        busy    <= 1'b1;
                        state   <= GET_A;
                    end
                end
                GET_A: begin
                    if (s_fire) begin
                        a_reg <= s_data;
                        state <= GET_B;
                    end
                end
                GET_B: begin
                    if (s_fire) begin
                        m_data  <= result;
                        m_valid <= 1'b1;
                        s_ready <= 1'b0;
                        state   <= OUT;
`ifdef ALU_STATUS_EN
                        status  <= {illegal, (result == '0)};
`endif
                    end
                end
                OUT: begin
                    // No bypass: the next opcode can only be taken the cycle after the handshake.
                    if (m_fire) begin
                        m_valid <= 1'b0;
                        s_ready <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                        if (op_count != {CNT_W{1'b1}}) begin
                            op_count <= op_count + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_alu_unit.sv
// Randomized self-checking bench for axi_alu_unit; a second instance with a 2-bit counter exercises saturation.
`timescale 1ns/1ps
module tb_axi_alu_unit;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 16;
    localparam int SAT_W  = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [DATA_W-1:0] s_data = '0;
    logic              s_valid = 1'b0;
    logic              m_ready = 1'b0;

    logic              s_ready;
    logic [DATA_W:0]   m_data;
    logic              m_valid;
    logic              busy;
    logic [CNT_W-1:0]  op_count;

    logic              sat_s_ready;
    logic [DATA_W:0]   sat_m_data;
    logic              sat_m_valid;
    logic              sat_busy;
    logic [SAT_W-1:0]  sat_op_count;
`ifdef ALU_STATUS_EN
    logic [1:0]        status;
    logic [1:0]        sat_status;
`endif

    int checks = 0;
    int failures = 0;
    int exp_cnt = 0;

    axi_alu_unit #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_dut (
        .clk      (clk),
        .reset    (reset),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .busy     (busy),
        .op_count (op_count)
`ifdef ALU_STATUS_EN
        ,
        .status   (status)
`endif
    );

    axi_alu_unit #(.DATA_W(DATA_W), .CNT_W(SAT_W)) u_sat (
        .clk      (clk),
        .reset    (reset),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (sat_s_ready),
        .m_data   (sat_m_data),
        .m_valid  (sat_m_valid),
        .m_ready  (m_ready),
        .busy     (sat_busy),
        .op_count (sat_op_count)
`ifdef ALU_STATUS_EN
        ,
        .status   (sat_status)
`endif
    );

    always #5 clk = ~clk;

    // Reference: the opcode table evaluated with plain integer arithmetic modulo 2^(DATA_W+1).
    function automatic logic [DATA_W:0] model(input int unsigned op, input int unsigned a, input int unsigned b);
        int unsigned modv;
        int unsigned sh;
        int unsigned r;
        modv = 1 << (DATA_W + 1);
        sh = b % DATA_W;
        if (op > 7) return '0;
        case (op)
            0: r = a + b;
            1: r = a + modv - b;
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = a * (1 << sh);
            6: r = a / (1 << sh);
            default: r = a;
        endcase
        r = r % modv;
        return r[DATA_W:0];
    endfunction

    function automatic int cap(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        s_valid = 1'b0;
        m_ready = 1'b0;
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        exp_cnt = 0;
    endtask

    task automatic send_beat(input logic [DATA_W-1:0] d, input int gap);
        bit ok;
        ok = 1'b0;
        for (int g = 0; g < gap; g++) begin
            s_valid = 1'b0;
            step();
        end
        s_data = d;
        s_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (s_ready) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL beat_accept: s_ready=%0b required 1 within 30 cycles", s_ready);
        end
        step();
        s_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] op, input logic [DATA_W-1:0] a,
                              input logic [DATA_W-1:0] b, input int gap);
        send_beat(op, 0);
        send_beat(a, gap);
        send_beat(b, gap);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({s_ready, m_valid, busy} !== 3'b100) begin
            failures++;
            $display("FAIL reset_ctrl: ready/valid/busy=%03b required 100", {s_ready, m_valid, busy});
        end
        checks++;
        if (m_data !== '0 || op_count !== '0 || sat_op_count !== '0) begin
            failures++;
            $display("FAIL reset_data: m_data=%h op_count=%0d sat=%0d required 0", m_data, op_count, sat_op_count);
        end
`ifdef ALU_STATUS_EN
        checks++;
        if (status !== 2'b00) begin
            failures++;
            $display("FAIL reset_status: status=%b required 00", status);
        end
`endif
    endtask

    task automatic test_directed();
        logic [DATA_W-1:0] ops [3] = '{8'h00, 8'h01, 8'h05};
        logic [DATA_W-1:0] as  [3] = '{8'hFF, 8'h03, 8'h81};
        logic [DATA_W-1:0] bs  [3] = '{8'h01, 8'h05, 8'h01};
        logic [DATA_W:0]   res [3] = '{9'h100, 9'h1FE, 9'h102};
        for (int k = 0; k < 3; k++) begin
            m_ready = 1'b0;
            send_frame(ops[k], as[k], bs[k], 0);
            checks++;
            if (m_valid !== 1'b1 || m_data !== res[k]) begin
                failures++;
                $display("FAIL directed_%0d: m_valid=%0b m_data=%h required 1 %h", k, m_valid, m_data, res[k]);
            end
            checks++;
            if (busy !== 1'b1 || s_ready !== 1'b0) begin
                failures++;
                $display("FAIL directed_out_%0d: busy=%0b s_ready=%0b required 1 0", k, busy, s_ready);
            end
            m_ready = 1'b1;
            step();
            m_ready = 1'b0;
            exp_cnt++;
            checks++;
            if (m_valid !== 1'b0 || s_ready !== 1'b1 || op_count !== CNT_W'(exp_cnt)) begin
                failures++;
                $display("FAIL directed_done_%0d: m_valid=%0b s_ready=%0b op_count=%0d required 0 1 %0d",
                         k, m_valid, s_ready, op_count, exp_cnt);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W:0]   exp;
        a = DATA_W'($urandom);
        b = DATA_W'($urandom);
        exp = model(0, a, b);
        m_ready = 1'b0;
        send_frame(8'h00, a, b, 0);
        s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_data = DATA_W'($urandom);
            step();
            checks++;
            if (m_valid !== 1'b1 || m_data !== exp || s_ready !== 1'b0) begin
                failures++;
                $display("FAIL backpressure_%0d: m_valid=%0b m_data=%h s_ready=%0b required 1 %h 0",
                         i, m_valid, m_data, s_ready, exp);
            end
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        exp_cnt++;
        checks++;
        if (op_count !== CNT_W'(exp_cnt) || busy !== 1'b0) begin
            failures++;
            $display("FAIL backpressure_done: op_count=%0d busy=%0b required %0d 0", op_count, busy, exp_cnt);
        end
    endtask

    task automatic test_illegal();
        m_ready = 1'b0;
        send_frame(8'h09, DATA_W'($urandom_range(1, 255)), DATA_W'($urandom), 0);
        checks++;
        if (m_valid !== 1'b1 || m_data !== '0) begin
            failures++;
            $display("FAIL illegal: m_valid=%0b m_data=%h required 1 000", m_valid, m_data);
        end
`ifdef ALU_STATUS_EN
        checks++;
        if (status !== 2'b11) begin
            failures++;
            $display("FAIL illegal_status: status=%b required 11", status);
        end
`endif
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        exp_cnt++;
    endtask

    task automatic test_reset_midframe();
        m_ready = 1'b0;
        send_beat(8'h00, 0);
        send_beat(8'h55, 0);
        reset = 1'b0;
        #2;
        checks++;
        if (busy !== 1'b0 || m_valid !== 1'b0 || op_count !== '0 || m_data !== '0) begin
            failures++;
            $display("FAIL midframe_reset: busy=%0b m_valid=%0b op_count=%0d m_data=%h required 0 0 0 0",
                     busy, m_valid, op_count, m_data);
        end
        step();
        reset = 1'b1;
        exp_cnt = 0;
        checks++;
        if (s_ready !== 1'b1) begin
            failures++;
            $display("FAIL midframe_ready: s_ready=%0b required 1", s_ready);
        end
        send_frame(8'h07, 8'h2A, 8'h00, 0);
        checks++;
        if (m_valid !== 1'b1 || m_data !== 9'h02A) begin
            failures++;
            $display("FAIL midframe_frame: m_valid=%0b m_data=%h required 1 02a", m_valid, m_data);
        end
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        exp_cnt++;
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W:0]   exp;
        int                wait_cyc;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 9) < 8) op = DATA_W'($urandom_range(0, 7));
            else op = DATA_W'($urandom_range(8, 255));
            a = DATA_W'($urandom);
            b = DATA_W'($urandom);
            exp = model(int'(op), int'(a), int'(b));
            m_ready = 1'b0;
            send_frame(op, a, b, $urandom_range(0, 2));
            checks++;
            if (m_valid !== 1'b1 || m_data !== exp) begin
                failures++;
                $display("FAIL random_%0d op=%h a=%h b=%h: m_valid=%0b m_data=%h required 1 %h",
                         n, op, a, b, m_valid, m_data, exp);
            end
`ifdef ALU_STATUS_EN
            checks++;
            if (status !== {op > 7, exp == 0}) begin
                failures++;
                $display("FAIL random_status_%0d: status=%b required %b", n, status, {op > 7, exp == 0});
            end
`endif
            wait_cyc = $urandom_range(0, 3);
            for (int w = 0; w < wait_cyc; w++) step();
            m_ready = 1'b1;
            step();
            m_ready = 1'b0;
            exp_cnt++;
            checks++;
            if (op_count !== CNT_W'(exp_cnt) || sat_op_count !== SAT_W'(cap(exp_cnt, 3))) begin
                failures++;
                $display("FAIL random_count_%0d: op_count=%0d sat=%0d required %0d %0d",
                         n, op_count, sat_op_count, exp_cnt, cap(exp_cnt, 3));
            end
        end
    endtask

    task automatic test_back_to_back();
        time t0;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        do_reset();
        m_ready = 1'b1;
        t0 = $time;
        for (int n = 0; n < 5; n++) begin
            a = DATA_W'($urandom);
            b = DATA_W'($urandom);
            send_frame(8'h04, a, b, 0);
            checks++;
            if (m_valid !== 1'b1 || m_data !== model(4, int'(a), int'(b))) begin
                failures++;
                $display("FAIL b2b_data_%0d: m_valid=%0b m_data=%h required 1 %h",
                         n, m_valid, m_data, model(4, int'(a), int'(b)));
            end
            step();
            exp_cnt++;
            checks++;
            if (sat_op_count !== SAT_W'(cap(exp_cnt, 3)) || op_count !== CNT_W'(exp_cnt)) begin
                failures++;
                $display("FAIL b2b_count_%0d: sat=%0d op_count=%0d required %0d %0d",
                         n, sat_op_count, op_count, cap(exp_cnt, 3), exp_cnt);
            end
        end
        m_ready = 1'b0;
        checks++;
        if ($time - t0 != 200) begin
            failures++;
            $display("FAIL b2b_throughput: elapsed=%0t required 200 (4 cycles per op)", $time - t0);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_illegal();
        test_reset_midframe();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
